// File: rtl/load_writeback_unit.sv
// Writeback stage: ALU results and aligned/extended load data to the register file.
// Optional misaligned-load trap is enabled with WB_MISALIGN_TRAP_EN.
module load_writeback_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        busy,
`ifdef WB_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM   = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             req_q;
  logic [31:0]      addr_q;
  logic             we_q;
  logic [4:0]       rf_rd_q;
  logic [31:0]      wdata_q;
  logic             busy_q;
  logic             to_q;
  logic [31:0]      ld_data_d;
  logic [7:0]       byte_l;
  logic [15:0]      half_l;
  logic             accept;
  logic             tmo_d;
  logic             mis_d;

  assign in_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept   = in_valid & in_ready;
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign tmo_d    = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

`ifdef WB_MISALIGN_TRAP_EN
  logic mis_q;
  logic is_half;
  logic is_word;

  assign is_half = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign is_word = !is_half && (in_funct3 != 3'b000) &&
                   (in_funct3 != 3'b100);
  assign mis_d   = in_is_load &&
                   ((is_half && in_alu_result[0]) ||
                    (is_word && (in_alu_result[1:0] != 2'b00)));
  assign misalign_err = mis_q;
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    byte_l = dmem_rdata[7:0];
    unique case (off_q)
      2'd0: byte_l = dmem_rdata[7:0];
      2'd1: byte_l = dmem_rdata[15:8];
      2'd2: byte_l = dmem_rdata[23:16];
      2'd3: byte_l = dmem_rdata[31:24];
      default: byte_l = dmem_rdata[7:0];
    endcase
    half_l = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  always_comb begin
    ld_data_d = dmem_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ld_data_d = {{24{byte_l[7]}}, byte_l};
      f3_q == 3'b100: ld_data_d = {24'd0, byte_l};
      f3_q == 3'b001: ld_data_d = {{16{half_l[15]}}, half_l};
      f3_q == 3'b101: ld_data_d = {16'd0, half_l};
      default:        ld_data_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      rf_rd_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      to_q <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE, WRITE: begin
          if (!accept) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!in_is_load) begin
            state_q <= WRITE;
            busy_q  <= 1'b1;
            we_q    <= (in_rd != 5'd0);
            rf_rd_q <= in_rd;
            wdata_q <= in_alu_result;
          end else if (mis_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            mis_q   <= 1'b1;
`endif
          end else begin
            state_q <= MEM;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            addr_q  <= {in_alu_result[31:2], 2'b00};
            off_q   <= in_alu_result[1:0];
            f3_q    <= in_funct3;
            rd_q    <= in_rd;
            cnt_q   <= '0;
          end
        end
        MEM: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (dmem_ack) begin
            state_q <= WRITE;
            busy_q  <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= (rd_q != 5'd0);
            rf_rd_q <= rd_q;
            wdata_q <= ld_data_d;
          end else if (tmo_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_addr   = addr_q;
  assign rf_we       = we_q;
  assign rf_rd       = rf_rd_q;
  assign rf_wdata    = wdata_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit with a per-cycle expectation model.
module tb_load_writeback_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        timeout_err;
`ifdef WB_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic        exp_mis = 1'b0;
`endif

  logic        exp_ready = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_req = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic        exp_to = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;
  int n_req = 0;

  load_writeback_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_is_load(in_is_load),
    .in_funct3(in_funct3),
    .in_rd(in_rd),
    .in_alu_result(in_alu_result),
    .dmem_req(dmem_req),
    .dmem_addr(dmem_addr),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_wdata(rf_wdata),
    .busy(busy),
`ifdef WB_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Load result straight from the ISA rules: shift the lane down, mask, extend.
  function automatic logic [31:0] extend(input logic [2:0] f3,
                                         input logic [31:0] addr,
                                         input logic [31:0] w);
    int sh;
    logic [31:0] v;
    v = w;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      sh = 8 * int'(addr[1:0]);
      v = (w >> sh) & 32'hFF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      sh = addr[1] ? 16 : 0;
      v = (w >> sh) & 32'hFFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic set_exp(input logic rdy, input logic bsy, input logic req,
                         input logic [31:0] addr, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic to);
    exp_ready = rdy;
    exp_busy  = bsy;
    exp_req   = req;
    exp_addr  = addr;
    exp_we    = we;
    exp_rd    = rd;
    exp_wdata = wd;
    exp_to    = to;
`ifdef WB_MISALIGN_TRAP_EN
    exp_mis   = 1'b0;
`endif
  endtask

  task automatic exp_idle();
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic drive(input logic v, input logic ld, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic ack, input logic [31:0] rdat);
    in_valid      = v;
    in_is_load    = ld;
    in_funct3     = f3;
    in_rd         = rd;
    in_alu_result = a;
    dmem_ack      = ack;
    dmem_rdata    = rdat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
      @(posedge clk);
      exp_idle();
    end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, rd, d, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b1, 1'b1, 1'b0, 32'd0, rd != 5'd0, rd, d, 1'b0);
  endtask

  task automatic mem_wait(input logic [31:0] a);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b0, 1'b1, 1'b1, a & ~32'd3, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] w,
                      input int delay, output logic [31:0] got);
    @(negedge clk);
    drive(1'b1, 1'b1, f3, rd, a, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b0, 1'b1, 1'b1, a & ~32'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < delay; i++) mem_wait(a);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, w);
    @(posedge clk);
    set_exp(1'b1, 1'b1, 1'b0, 32'd0, rd != 5'd0, rd, extend(f3, a, w), 1'b0);
    #3;
    got = rf_wdata;
  endtask

  always @(posedge clk) begin
    #2;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(exp_busy));
    check("dmem_req", 32'(dmem_req), 32'(exp_req));
    if (exp_req) check("dmem_addr", dmem_addr, exp_addr);
    check("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      check("rf_rd", 32'(rf_rd), 32'(exp_rd));
      check("rf_wdata", rf_wdata, exp_wdata);
    end
    check("timeout_err", 32'(timeout_err), 32'(exp_to));
`ifdef WB_MISALIGN_TRAP_EN
    check("misalign_err", 32'(misalign_err), 32'(exp_mis));
`endif
    if (rf_we) n_writes++;
    if (dmem_req) n_req++;
  end

  initial begin
    logic [31:0] got;
    int w0;
    int r0;

    check("model_lb", extend(3'd0, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    check("model_lhu", extend(3'd5, 32'h102, 32'h8001_1234), 32'h0000_8001);
    check("model_lh", extend(3'd1, 32'h100, 32'h1234_8001), 32'hFFFF_8001);

    exp_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    w0 = n_writes;
    alu(5'd5, 32'hDEAD_BEEF);
    #3;
    check("alu_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("alu_rd", 32'(rf_rd), 32'd5);
    alu(5'd1, 32'h11);
    alu(5'd2, 32'h22);
    alu(5'd0, 32'h33);
    idle(1);
    #3;
    check("alu_writes", 32'(n_writes - w0), 32'd3);

    w0 = n_writes;
    load(3'd0, 5'd7, 32'h103, 32'h80FF_0000, 3, got);
    check("lb_data", got, 32'hFFFF_FF80);
    idle(1);
    #3;
    check("lb_writes", 32'(n_writes - w0), 32'd1);

    load(3'd5, 5'd8, 32'h102, 32'h8001_1234, 0, got);
    check("lhu_data", got, 32'h0000_8001);
    load(3'd1, 5'd9, 32'h100, 32'h1234_8001, 1, got);
    check("lh_data", got, 32'hFFFF_8001);
    load(3'd4, 5'd10, 32'h103, 32'h80FF_0000, 0, got);
    check("lbu_data", got, 32'h0000_0080);
    load(3'd0, 5'd11, 32'h101, 32'h0000_7F00, 2, got);
    check("lb_pos", got, 32'h0000_007F);
    load(3'd3, 5'd12, 32'h204, 32'hCAFE_BABE, 2, got);
    check("f3_011", got, 32'hCAFE_BABE);
    alu(5'd13, 32'h1357_9BDF);
    idle(1);

    w0 = n_writes;
    load(3'd2, 5'd0, 32'h200, 32'h5555_AAAA, 1, got);
    idle(1);
    #3;
    check("x0_writes", 32'(n_writes - w0), 32'd0);

    load(3'd2, 5'd14, 32'h300, 32'h0BAD_F00D, TMO - 1, got);
    check("ack_at_tmo", got, 32'h0BAD_F00D);
    idle(1);

    r0 = n_req;
    w0 = n_writes;
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd2, 5'd15, 32'h400, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) mem_wait(32'h400);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(2);
    #3;
    check("tmo_req_cycles", 32'(n_req - r0), 32'd16);
    check("tmo_writes", 32'(n_writes - w0), 32'd0);

    w0 = n_writes;
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd3, 32'd0, 1'b1, 32'hFFFF_FFFF);
    @(posedge clk);
    exp_idle();
    idle(1);

    @(negedge clk);
    drive(1'b1, 1'b1, 3'd2, 5'd16, 32'h500, 1'b0, 32'd0);
    @(posedge clk);
    set_exp(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
    mem_wait(32'h500);
    mem_wait(32'h500);
    @(negedge clk);
    reset = 1'b1;
    exp_idle();
    #1;
    check("rst_mid_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h1234_5678);
    @(posedge clk);
    exp_idle();
    idle(2);
    #3;
    check("no_stray_writes", 32'(n_writes - w0), 32'd0);

`ifdef WB_MISALIGN_TRAP_EN
    r0 = n_req;
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd2, 5'd17, 32'h101, 1'b0, 32'd0);
    @(posedge clk);
    exp_idle();
    exp_mis = 1'b1;
    idle(2);
    #3;
    check("mis_req", 32'(n_req - r0), 32'd0);
`else
    load(3'd2, 5'd17, 32'h101, 32'hA5A5_0F0F, 1, got);
    check("lw_unaligned", got, 32'hA5A5_0F0F);
    idle(1);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
